// File: rtl/display_pkg.sv
// Shared display-path definitions: byte-phase enum and the line-buffer geometry
// used by the write-side demux, the read-side muxes and the buffers themselves.
package display_pkg;

  localparam int DEPTH_DEFAULT  = 640;
  localparam int ADDR_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    GET_R = 2'd0,
    GET_G = 2'd1,
    GET_B = 2'd2
  } phase_e;

endpackage

// File: rtl/pixel_addr_ctr.sv
// Pixel write-address counter for the ping-pong line buffers: counts 0..DEPTH-1,
// wraps on the last pixel and flips the target buffer at the same time.
module pixel_addr_ctr
  import display_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              inc,
  input  logic              clear,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap,
  output logic              target
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  assign wrap = inc && (addr == LastAddr);

  // clear restarts a frame: address 0 and Buf0, regardless of any increment
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      addr   <= '0;
      target <= 1'b0;
    end else if (clear) begin
      addr   <= '0;
      target <= 1'b0;
    end else if (wrap) begin
      addr   <= '0;
      target <= ~target;
    end else if (inc) begin
      addr   <= addr + 1'b1;
    end
  end

endmodule

// File: rtl/rgb_byte_demux.sv
// Write-side RGB demux: assembles R,G,B byte triples into 24-bit pixels and
// strobes them into the Buf0/Buf1 ping-pong line buffers.
module rgb_byte_demux
  import display_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic [7:0]        DataIn,
  input  logic              DataValid,
  input  logic              FrameStart,
  input  logic              Buf0Free,
  input  logic              Buf1Free,
  output logic              Ready,
  output logic [7:0]        WrR,
  output logic [7:0]        WrG,
  output logic [7:0]        WrB,
  output logic [ADDR_W-1:0] WrAddr,
  output logic              WrEn0,
  output logic              WrEn1,
  output logic              BufDone0,
  output logic              BufDone1,
  output logic              Overflow
);

  phase_e            phase;
  logic [7:0]        rHold;
  logic [7:0]        gHold;
  logic [ADDR_W-1:0] addr;
  logic              wrap;
  logic              target;
  logic              accept;
  logic              pixelDone;

  // FrameStart takes priority, so a byte arriving with it is never accepted
  assign accept    = DataValid && Ready && !FrameStart;
  assign pixelDone = accept && (phase == GET_B);

  pixel_addr_ctr #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_addrCtr (
    .Clock (Clock),
    .ResetN(ResetN),
    .inc   (pixelDone),
    .clear (FrameStart),
    .addr  (addr),
    .wrap  (wrap),
    .target(target)
  );

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      phase    <= GET_R;
      rHold    <= '0;
      gHold    <= '0;
      Ready    <= 1'b0;
      WrR      <= '0;
      WrG      <= '0;
      WrB      <= '0;
      WrAddr   <= '0;
      WrEn0    <= 1'b0;
      WrEn1    <= 1'b0;
      BufDone0 <= 1'b0;
      BufDone1 <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      Ready    <= target ? Buf1Free : Buf0Free;
      WrEn0    <= pixelDone && !target;
      WrEn1    <= pixelDone && target;
      BufDone0 <= wrap && !target;
      BufDone1 <= wrap && target;

      // no back-pressure: a byte offered while not ready is lost for good
      if (DataValid && !Ready) begin
        Overflow <= 1'b1;
      end

      if (pixelDone) begin
        WrR    <= rHold;
        WrG    <= gHold;
        WrB    <= DataIn;
        WrAddr <= addr;
      end

      if (FrameStart) begin
        phase <= GET_R;
      end else if (accept) begin
        case (phase)
          GET_R: begin
            rHold <= DataIn;
            phase <= GET_G;
          end
          GET_G: begin
            gHold <= DataIn;
            phase <= GET_B;
          end
          default: phase <= GET_R;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rgb_byte_demux.sv
// Self-checking bench for rgb_byte_demux: directed scenarios plus random traffic,
// compared every cycle against a pixel-index based reference model.
module tb_rgb_byte_demux;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 3;

  logic              Clock = 1'b0;
  logic              ResetN;
  logic [7:0]        DataIn;
  logic              DataValid;
  logic              FrameStart;
  logic              Buf0Free;
  logic              Buf1Free;
  logic              Ready;
  logic [7:0]        WrR;
  logic [7:0]        WrG;
  logic [7:0]        WrB;
  logic [ADDR_W-1:0] WrAddr;
  logic              WrEn0;
  logic              WrEn1;
  logic              BufDone0;
  logic              BufDone1;
  logic              Overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model: pixel number since frame start decides address and buffer
  logic              mReady;
  logic              mOverflow;
  int                mCount;
  int                mPixIdx;
  logic [7:0]        mHold [0:1];
  logic              eWrEn0, eWrEn1, eDone0, eDone1;
  logic [7:0]        eR, eG, eB;
  logic [ADDR_W-1:0] eAddr;

  rgb_byte_demux #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .Clock     (Clock),
    .ResetN    (ResetN),
    .DataIn    (DataIn),
    .DataValid (DataValid),
    .FrameStart(FrameStart),
    .Buf0Free  (Buf0Free),
    .Buf1Free  (Buf1Free),
    .Ready     (Ready),
    .WrR       (WrR),
    .WrG       (WrG),
    .WrB       (WrB),
    .WrAddr    (WrAddr),
    .WrEn0     (WrEn0),
    .WrEn1     (WrEn1),
    .BufDone0  (BufDone0),
    .BufDone1  (BufDone1),
    .Overflow  (Overflow)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic resetModel();
    mReady    = 1'b0;
    mOverflow = 1'b0;
    mCount    = 0;
    mPixIdx   = 0;
    mHold[0]  = '0;
    mHold[1]  = '0;
    eWrEn0    = 1'b0;
    eWrEn1    = 1'b0;
    eDone0    = 1'b0;
    eDone1    = 1'b0;
    eR        = '0;
    eG        = '0;
    eB        = '0;
    eAddr     = '0;
  endtask

  task automatic checkOutput(input string step);
    check({step, " Ready"},    32'(Ready),    32'(mReady));
    check({step, " WrEn0"},    32'(WrEn0),    32'(eWrEn0));
    check({step, " WrEn1"},    32'(WrEn1),    32'(eWrEn1));
    check({step, " BufDone0"}, 32'(BufDone0), 32'(eDone0));
    check({step, " BufDone1"}, 32'(BufDone1), 32'(eDone1));
    check({step, " Overflow"}, 32'(Overflow), 32'(mOverflow));
    check({step, " WrR"},      32'(WrR),      32'(eR));
    check({step, " WrG"},      32'(WrG),      32'(eG));
    check({step, " WrB"},      32'(WrB),      32'(eB));
    check({step, " WrAddr"},   32'(WrAddr),   32'(eAddr));
  endtask

  // Drives one cycle of input, advances the model across the edge, then checks
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic fs,
                               input string step);
    int curTarget;
    logic newReady;
    DataValid  = v;
    DataIn     = d;
    FrameStart = fs;
    @(posedge Clock);
    curTarget = (mPixIdx / DEPTH) % 2;
    newReady  = (curTarget == 1) ? Buf1Free : Buf0Free;
    eWrEn0 = 1'b0;
    eWrEn1 = 1'b0;
    eDone0 = 1'b0;
    eDone1 = 1'b0;
    if (v && !mReady) mOverflow = 1'b1;
    if (fs) begin
      mCount  = 0;
      mPixIdx = 0;
    end else if (v && mReady) begin
      if (mCount < 2) begin
        mHold[mCount] = d;
        mCount++;
      end else begin
        eR    = mHold[0];
        eG    = mHold[1];
        eB    = d;
        eAddr = ADDR_W'(mPixIdx % DEPTH);
        if (curTarget == 1) eWrEn1 = 1'b1;
        else                eWrEn0 = 1'b1;
        if ((mPixIdx % DEPTH) == DEPTH - 1) begin
          if (curTarget == 1) eDone1 = 1'b1;
          else                eDone0 = 1'b1;
        end
        mPixIdx++;
        mCount = 0;
      end
    end
    mReady = newReady;
    #1;
    checkOutput(step);
  endtask

  task automatic applyAsyncReset(input string step);
    ResetN = 1'b0;
    #1;
    resetModel();
    checkOutput(step);
    @(negedge Clock);
    ResetN = 1'b1;
  endtask

  initial begin
    ResetN     = 1'b0;
    DataIn     = '0;
    DataValid  = 1'b0;
    FrameStart = 1'b0;
    Buf0Free   = 1'b1;
    Buf1Free   = 1'b1;
    resetModel();
    #12;
    checkOutput("reset");
    ResetN = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, "idle0");

    $display("[TB] basic pixel");
    applyStimulus(1'b1, 8'h11, 1'b0, "basicR");
    applyStimulus(1'b1, 8'h22, 1'b0, "basicG");
    applyStimulus(1'b1, 8'h33, 1'b0, "basicB");
    check("basic WrEn0 const", 32'(WrEn0), 32'd1);
    check("basic WrR const", 32'(WrR), 32'h11);
    check("basic WrG const", 32'(WrG), 32'h22);
    check("basic WrB const", 32'(WrB), 32'h33);
    check("basic WrAddr const", 32'(WrAddr), 32'd0);
    check("basic Overflow const", 32'(Overflow), 32'd0);

    $display("[TB] continuous stream across buffer wrap");
    applyStimulus(1'b0, 8'h00, 1'b1, "fs1");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, 8'($urandom), 1'b0, "cont");
      if (i == 11) check("cont BufDone0 at addr3", 32'(BufDone0), 32'd1);
    end
    check("cont fifth pixel WrEn1", 32'(WrEn1), 32'd1);
    check("cont fifth pixel addr", 32'(WrAddr), 32'd0);

    $display("[TB] busy Buf1 drops bytes");
    applyStimulus(1'b0, 8'h00, 1'b1, "fs2");
    Buf1Free = 1'b0;
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, "fill0");
    applyStimulus(1'b0, 8'h00, 1'b0, "wait1");
    applyStimulus(1'b0, 8'h00, 1'b0, "wait2");
    check("busy Ready low", 32'(Ready), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, "drop");
    check("busy Overflow set", 32'(Overflow), 32'd1);
    Buf1Free = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, "release");
    applyStimulus(1'b1, 8'h44, 1'b0, "buf1R");
    applyStimulus(1'b1, 8'h55, 1'b0, "buf1G");
    applyStimulus(1'b1, 8'h66, 1'b0, "buf1B");
    check("buf1 WrEn1 const", 32'(WrEn1), 32'd1);
    check("buf1 WrAddr const", 32'(WrAddr), 32'd0);
    check("buf1 WrB const", 32'(WrB), 32'h66);

    $display("[TB] FrameStart mid-pixel");
    applyStimulus(1'b0, 8'h00, 1'b1, "fs3");
    applyStimulus(1'b1, 8'h01, 1'b0, "partR");
    applyStimulus(1'b1, 8'h02, 1'b0, "partG");
    applyStimulus(1'b1, 8'h5A, 1'b1, "fsByte");
    applyStimulus(1'b1, 8'hAA, 1'b0, "fsR");
    applyStimulus(1'b1, 8'hBB, 1'b0, "fsG");
    applyStimulus(1'b1, 8'hCC, 1'b0, "fsB");
    check("fs WrEn0 const", 32'(WrEn0), 32'd1);
    check("fs WrAddr const", 32'(WrAddr), 32'd0);
    check("fs pixel const", {8'h0, WrR, WrG, WrB}, 32'h00AABBCC);

    $display("[TB] gapped stream");
    applyStimulus(1'b0, 8'h00, 1'b1, "fs4");
    for (int i = 0; i < 18; i++) begin
      repeat ($urandom_range(1, 4)) applyStimulus(1'b0, 8'h00, 1'b0, "gap");
      applyStimulus(1'b1, 8'($urandom), 1'b0, "gapByte");
    end

    $display("[TB] async reset mid-pixel");
    applyStimulus(1'b0, 8'h00, 1'b1, "fs5");
    applyStimulus(1'b1, 8'h77, 1'b0, "rstR");
    applyStimulus(1'b1, 8'h88, 1'b0, "rstG");
    applyAsyncReset("asyncReset");
    applyStimulus(1'b0, 8'h00, 1'b0, "postRst1");
    applyStimulus(1'b0, 8'h00, 1'b0, "postRst2");
    applyStimulus(1'b1, 8'h12, 1'b0, "postR");
    applyStimulus(1'b1, 8'h34, 1'b0, "postG");
    applyStimulus(1'b1, 8'h56, 1'b0, "postB");
    check("postRst WrEn0 const", 32'(WrEn0), 32'd1);
    check("postRst WrAddr const", 32'(WrAddr), 32'd0);
    check("postRst WrR const", 32'(WrR), 32'h12);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      logic v;
      logic fs;
      if ($urandom_range(0, 7) == 0) Buf0Free = ~Buf0Free;
      if ($urandom_range(0, 7) == 0) Buf1Free = ~Buf1Free;
      v  = 1'($urandom_range(0, 3) != 0);
      fs = !v && ($urandom_range(0, 31) == 0);
      applyStimulus(v, 8'($urandom), fs, "rand");
      check("rand strobe exclusive", 32'(WrEn0 && WrEn1), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
